// File: rtl/sat_pkg.sv
// Shared types for the BCP imply-stack control path.
// Holds variable width, variable count, implication record and FSM states.
package sat_pkg;

   localparam int VAR_W        = 9;
   localparam int NUM_VARIABLE = 128;

   typedef struct packed {
      logic             val;
      logic [VAR_W-1:0] variable;
   } implication_t;

   typedef enum logic {
      RUN,
      FLUSH
   } state_t;

endpackage

// File: rtl/imply_stack_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer.
// Ports: clk, reset, req, en in; grant (one-hot) and grant_idx out.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx
);

   logic [PTR_W-1:0] ptr;

   always_comb begin
      logic             found;
      int               j;
      logic [PTR_W-1:0] jj;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      jj        = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         jj = j[PTR_W-1:0];
         if (en && !found && req[jj]) begin
            found     = 1'b1;
            grant[jj] = 1'b1;
            grant_idx = jj;
         end
      end
   end

   // Pointer moves just past the index that was served.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (|grant) begin
         if (grant_idx == PTR_W'(NUM_REQ - 1)) ptr <= '0;
         else                                  ptr <= grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/imply_stack_ctrl.sv
// Imply stack sequencer: arbitrates evaluator implications into pushes,
// serves pops, drops duplicates, flags conflicts and flushes the stack.
// Ports: clk, reset, clear; req_valid/req_var/req_val -> req_ready;
// pop_req -> pop_valid/pop_var/pop_val; conflict, conflict_var, range_err,
// count; stk_en/stk_rw/stk_reset/stk_val/stk_variable to the stack and
// stk_val_out/stk_variable_out back from it.
module imply_stack_ctrl
   import sat_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int NUM_VARIABLE = sat_pkg::NUM_VARIABLE,
   parameter int VAR_W        = sat_pkg::VAR_W,
   parameter int DEPTH        = 128,
   parameter int CNT_W        = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*VAR_W-1:0] req_var,
   input  logic [NUM_REQ-1:0]       req_val,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     pop_req,
   output logic                     pop_valid,
   output logic [VAR_W-1:0]         pop_var,
   output logic                     pop_val,
   output logic                     conflict,
   output logic [VAR_W-1:0]         conflict_var,
   output logic                     range_err,
   output logic [CNT_W-1:0]         count,
   output logic                     stk_en,
   output logic                     stk_rw,
   output logic                     stk_reset,
   output logic                     stk_val,
   output logic [VAR_W-1:0]         stk_variable,
   input  logic                     stk_val_out,
   input  logic [VAR_W-1:0]         stk_variable_out
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int IDX_W = (NUM_VARIABLE > 1) ? $clog2(NUM_VARIABLE) : 1;

   state_t                  state;
   logic [CNT_W-1:0]        count_q;
   logic                    prev_nz;
   logic [NUM_VARIABLE-1:0] implied;
   logic [NUM_VARIABLE-1:0] value;

   logic                    run;
   logic                    flush;
   logic                    pop_go;
   logic                    arb_en;
   logic [NUM_REQ-1:0]      grant;
   logic [PTR_W-1:0]        grant_idx;
   logic                    acc;
   implication_t            sel;
   logic                    in_range;
   logic [IDX_W-1:0]        bidx;
   logic                    hit;
   logic                    push_go;
   logic                    conf_go;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req_valid),
      .en        (arb_en),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      flush = reset || (state == FLUSH);
      run   = !reset && (state == RUN) && !clear;
      // Stack empty flag lags a cycle, so a pop also needs last cycle nonzero.
      pop_go = run && pop_req && (count_q != '0) && prev_nz;
      arb_en = run && !pop_go && (count_q < CNT_W'(DEPTH));

      acc          = |grant;
      sel.variable = req_var[int'(grant_idx)*VAR_W +: VAR_W];
      sel.val      = req_val[grant_idx];
      in_range     = sel.variable < VAR_W'(NUM_VARIABLE);
      bidx         = sel.variable[IDX_W-1:0];
      hit          = implied[bidx];
      push_go      = acc && in_range && !hit;
      conf_go      = acc && in_range && hit && (value[bidx] != sel.val);

      req_ready    = grant;
      stk_en       = flush || push_go || pop_go;
      stk_rw       = !flush && push_go;
      stk_reset    = flush;
      stk_val      = sel.val;
      stk_variable = sel.variable;
   end

   assign count   = count_q;
   assign pop_var = stk_variable_out;
   assign pop_val = stk_val_out;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= FLUSH;
         count_q      <= '0;
         prev_nz      <= 1'b0;
         implied      <= '0;
         value        <= '0;
         pop_valid    <= 1'b0;
         conflict     <= 1'b0;
         conflict_var <= '0;
         range_err    <= 1'b0;
      end else begin
         prev_nz   <= (count_q != '0);
         pop_valid <= pop_go;
         conflict  <= conf_go;
         range_err <= acc && !in_range;
         if (conf_go) conflict_var <= sel.variable;
         unique case (state)
            FLUSH: begin
               state   <= RUN;
               count_q <= '0;
               prev_nz <= 1'b0;
               implied <= '0;
               value   <= '0;
            end
            RUN: begin
               if (clear || conf_go) state <= FLUSH;
               if (push_go) begin
                  count_q       <= count_q + 1'b1;
                  implied[bidx] <= 1'b1;
                  value[bidx]   <= sel.val;
               end else if (pop_go) begin
                  count_q <= count_q - 1'b1;
               end
            end
         endcase
      end
   end

endmodule
